// File: rtl/cpu_reset_sequencer.sv
// Core reset / fetch-stall sequencer for the pipelined RISC-V core.
// Sequence: hold reset, wait for imem preload, release, run; soft reset drains the pipeline first.
module cpu_reset_sequencer #(
   parameter int HOLD_CYCLES  = 16,
   parameter int DRAIN_CYCLES = 5,
   parameter int LOAD_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       imem_load_done,
   input  logic       soft_rst_req,
   output logic       core_reset_n,
   output logic       fetch_stall,
   output logic       boot_done,
   output logic       load_timeout,
   output logic [7:0] reset_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOAD = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_DRAIN     = 3'd4
   } state_e;

   // One shared counter serves both HOLD and DRAIN, so size it for the longer of the two.
   localparam int CNT_MAX = (HOLD_CYCLES > DRAIN_CYCLES) ? HOLD_CYCLES : DRAIN_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int TW      = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);
   localparam bit            TMO_EN     = (LOAD_TIMEOUT != 0);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            load_timeout_q, load_timeout_d;
   logic [7:0]      reset_count_q, reset_count_d;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      load_timeout_d = load_timeout_q;
      reset_count_d  = reset_count_q;

      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d   = ST_WAIT_LOAD;
               cnt_d     = '0;
               tmo_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_WAIT_LOAD: begin
            // A load completing this cycle wins over the timeout.
            if (imem_load_done) begin
               state_d = ST_RELEASE;
            end else if (TMO_EN) begin
               if (tmo_cnt_q == TMO_LAST) begin
                  load_timeout_d = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
            end
         end

         ST_RELEASE: begin
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (soft_rst_req) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end

         ST_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               if (reset_count_q != 8'hFF) begin
                  reset_count_d = reset_count_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            tmo_cnt_d = '0;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_HOLD;
         cnt_q          <= '0;
         tmo_cnt_q      <= '0;
         load_timeout_q <= 1'b0;
         reset_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         load_timeout_q <= load_timeout_d;
         reset_count_q  <= reset_count_d;
      end
   end

   // Moore decode; unknown codes look like HOLD until the next edge recovers them.
   always_comb begin
      core_reset_n = 1'b0;
      fetch_stall  = 1'b1;
      boot_done    = 1'b0;
      case (state_q)
         ST_RELEASE: core_reset_n = 1'b1;
         ST_DRAIN:   core_reset_n = 1'b1;
         ST_RUN: begin
            core_reset_n = 1'b1;
            fetch_stall  = 1'b0;
            boot_done    = 1'b1;
         end
         default: ;
      endcase
   end

   assign load_timeout = load_timeout_q;
   assign reset_count  = reset_count_q;
   assign state        = state_q;

endmodule
